decimator_multich: RTL and testbench

Parametrised successor of the single-channel fixed-factor downsampler. Accepts time-interleaved signed samples for NUM_CH channels under an input-valid strobe and decimates by a run-time-fixed factor DECIM. Two modes per decimation frame:
- pick: keep one sample per channel.
- integrate-and-dump: sum DECIM samples per channel.

Sits between the ADC/filter front end and the demodulator on the CLOCK_50 domain.

---
 rtl/dsp_pkg.sv | 15 +
 rtl/decim_accum.sv | 45 ++++
 rtl/decimator_multich.sv | 94 +++++++++
 tb/tb_decimator_multich.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the decimator datapath.
// Mode encodings and output width helper.
package dsp_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_SUM  = 1'b1;

  function automatic int sum_width(
    input int data_w,
    input int decim
  );
    return data_w + $clog2(decim);
  endfunction

endpackage

// File: rtl/decim_accum.sv
// Per-channel pick / integrate-and-dump cell.
// nxt is the value acc takes at the coming edge.
module decim_accum
  import dsp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     first,
  input  logic                     last,
  input  logic                     mode,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [SUM_W-1:0]  nxt
);

  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] ext;

  assign ext = {{(SUM_W-DATA_W){sample[DATA_W-1]}}, sample};

  // Phase 0 always reloads, so a stale sum never leaks into a new frame.
  always_comb begin
    nxt = acc;
    if (en) begin
      if (first)
        nxt = ext;
      else if (mode == MODE_SUM)
        nxt = acc + ext;
      else if (last)
        nxt = ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr)
      acc <= '0;
    else
      acc <= nxt;
  end

endmodule

// File: rtl/decimator_multich.sv
// Multi-channel decimator: interleaved samples in,
// one pick or summed value per channel per frame out.
module decimator_multich
  import dsp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DECIM  = 6,
  localparam int SUM_W = sum_width(DATA_W, DECIM)
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  data_in,
  input  logic                      mode,
  input  logic                      sync_clr,
  output logic [NUM_CH*SUM_W-1:0]   down_data_out,
  output logic                      out_valid,
  output logic                      frame_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PH_W = $clog2(DECIM);

  logic [CH_W-1:0] ch_cnt;
  logic [PH_W-1:0] phase_cnt;
  logic            mode_lat;
  logic            accept;
  logic            frame_start;
  logic            ch_last;
  logic            ph_last;
  logic            eff_mode;
  logic            done;

  logic [NUM_CH-1:0][SUM_W-1:0] nxt;

  assign accept      = in_valid & ~sync_clr;
  assign frame_start = (ch_cnt == '0) && (phase_cnt == '0);
  assign ch_last     = ch_cnt == CH_W'(NUM_CH - 1);
  assign ph_last     = phase_cnt == PH_W'(DECIM - 1);
  assign done        = accept & ch_last & ph_last;

  // The first sample of a frame already obeys the incoming mode.
  assign eff_mode = frame_start ? mode : mode_lat;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    decim_accum #(
      .DATA_W(DATA_W),
      .SUM_W (SUM_W)
    ) u_cell (
      .clk   (CLOCK_50),
      .reset (reset),
      .clr   (sync_clr),
      .en    (accept && (ch_cnt == CH_W'(k))),
      .first (phase_cnt == '0),
      .last  (ph_last),
      .mode  (eff_mode),
      .sample(data_in),
      .nxt   (nxt[k])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ch_cnt        <= '0;
      phase_cnt     <= '0;
      mode_lat      <= MODE_PICK;
      out_valid     <= 1'b0;
      frame_err     <= 1'b0;
      down_data_out <= '0;
    end else begin
      out_valid <= done;
      if (in_valid && sync_clr)
        frame_err <= 1'b1;
      if (sync_clr) begin
        ch_cnt    <= '0;
        phase_cnt <= '0;
      end else if (accept) begin
        if (frame_start)
          mode_lat <= mode;
        if (ch_last) begin
          ch_cnt    <= '0;
          phase_cnt <= ph_last ? '0 : phase_cnt + 1'b1;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
      // Capture every slot from nxt so the last channel lands this edge too.
      if (done)
        down_data_out <= nxt;
    end
  end

endmodule

// File: tb/tb_decimator_multich.sv
// Bench for decimator_multich: directed frames plus random
// traffic against a frame-buffer reference model.
module tb_decimator_multich;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 2;
  localparam int DECIM  = 6;
  localparam int SUM_W  = 19;
  localparam int FRAME  = NUM_CH * DECIM;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] data_in;
  logic                     mode;
  logic                     sync_clr;
  logic [NUM_CH*SUM_W-1:0]  down_data_out;
  logic                     out_valid;
  logic                     frame_err;

  int checks = 0;
  int failures = 0;

  int                      fbuf[$];
  bit                      fmode;
  bit                      exp_err;
  bit                      exp_valid;
  logic [NUM_CH*SUM_W-1:0] exp_dout;

  always #10 clk = ~clk;

  decimator_multich #(
    .DATA_W(DATA_W),
    .NUM_CH(NUM_CH),
    .DECIM (DECIM)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .mode         (mode),
    .sync_clr     (sync_clr),
    .down_data_out(down_data_out),
    .out_valid    (out_valid),
    .frame_err    (frame_err)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint slot(input int k);
    logic [SUM_W-1:0] v;
    v = down_data_out[k*SUM_W +: SUM_W];
    return longint'($signed(v));
  endfunction

  task automatic finish_frame();
    for (int k = 0; k < NUM_CH; k++) begin
      longint s = 0;
      if (fmode)
        for (int p = 0; p < DECIM; p++) s += fbuf[p*NUM_CH + k];
      else
        s = fbuf[(DECIM-1)*NUM_CH + k];
      exp_dout[k*SUM_W +: SUM_W] = SUM_W'(s);
    end
    exp_valid = 1'b1;
    fbuf.delete();
  endtask

  task automatic step(input bit v, input int d, input bit m, input bit c);
    in_valid = v;
    data_in  = DATA_W'(d);
    mode     = m;
    sync_clr = c;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (c) begin
      if (v) exp_err = 1'b1;
      fbuf.delete();
    end else if (v) begin
      if (fbuf.size() == 0) fmode = m;
      fbuf.push_back(int'($signed(DATA_W'(d))));
      if (fbuf.size() == FRAME) finish_frame();
    end
    chk("out_valid", longint'(out_valid), longint'(exp_valid));
    chk("dout", longint'(down_data_out), longint'(exp_dout));
    chk("frame_err", longint'(frame_err), longint'(exp_err));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'sd77;
    mode     = 1'b1;
    sync_clr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    fbuf.delete();
    exp_err  = 1'b0;
    exp_dout = '0;
    chk("rst_dout", longint'(down_data_out), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_err", longint'(frame_err), 0);
  endtask

  task automatic ramp(input bit m);
    for (int i = 1; i <= FRAME; i++) step(1, i, m, 0);
  endtask

  task automatic slots(input string tag, input longint a, input longint b);
    chk({tag, "_ch0"}, slot(0), a);
    chk({tag, "_ch1"}, slot(1), b);
  endtask

  function automatic int rnd_sample();
    int r = int'($urandom_range(0, 7));
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    do_reset();

    ramp(0);
    slots("pick", 11, 12);
    step(0, 0, 0, 0);

    ramp(1);
    slots("sum", 36, 42);

    for (int i = 0; i < FRAME; i++) step(1, -32768, 1, 0);
    slots("sum_min", -196608, -196608);
    for (int i = 0; i < FRAME; i++) step(1, 32767, 1, 0);
    slots("sum_max", 196602, 196602);

    for (int i = 1; i <= FRAME; i++) begin
      step(1, i, 1, 0);
      if (i < FRAME) begin
        step(0, 500, 1, 0);
        step(0, 600, 0, 0);
      end
    end
    slots("sparse", 36, 42);

    for (int i = 1; i <= FRAME; i++) step(1, i, i > 5, 0);
    slots("mode_chg", 11, 12);
    ramp(1);
    slots("mode_next", 36, 42);

    for (int i = 1; i <= 7; i++) step(1, i, 0, 0);
    step(1, 99, 0, 1);
    chk("clr_err", longint'(frame_err), 1);
    step(0, 0, 0, 0);
    ramp(0);
    slots("after_clr", 11, 12);

    for (int i = 1; i <= 5; i++) step(1, i, 1, 0);
    do_reset();
    step(0, 0, 0, 0);
    ramp(1);
    slots("after_rst", 36, 42);

    for (int n = 0; n < 3000; n++) begin
      bit v = ($urandom_range(0, 9) < 7);
      bit c = ($urandom_range(0, 59) == 0);
      bit m = $urandom_range(0, 1) != 0;
      step(v, rnd_sample(), m, c);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
